// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder stage for the radix-2 DIF FFT output, with sop/eop/bin markers.
// Optional FFT_REORDER_MAG_EN adds a registered |X|^2 output and one extra pipeline stage.
module fft_bitrev_reorder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned POW        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] sink_r,
  input  logic [DATA_WIDTH-1:0] sink_i,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic [POW-1:0]        bin_idx,
  output logic [DATA_WIDTH-1:0] source_r,
  output logic [DATA_WIDTH-1:0] source_i
`ifdef FFT_REORDER_MAG_EN
  ,
  output logic [2*DATA_WIDTH:0] source_mag
`endif
);

  localparam int unsigned N  = 2 ** POW;
  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned MW = 2 * DATA_WIDTH + 1;
  localparam logic [POW-1:0] LAST_IDX = POW'(N - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic logic [POW-1:0] bitrev(input logic [POW-1:0] x);
    logic [POW-1:0] y;
    y = '0;
    for (int b = 0; b < POW; b++) begin
      y[b] = x[POW-1-b];
    end
    return y;
  endfunction

  // Write side: linear fill of the ping-pong bank selected by wr_bank
  logic [POW-1:0] wr_idx;
  logic           wr_bank;
  logic           wr_last_c;
  logic [1:0]     full;
  logic [1:0]     full_set_c;
  logic [1:0]     full_clr_c;
  sample_t        wr_data_c;
  sample_t        mem [2*N];

  assign wr_last_c = valid_in && (wr_idx == LAST_IDX);
  assign wr_data_c = '{re: sink_r, im: sink_i};

  always_comb begin
    full_set_c = '0;
    if (wr_last_c) begin
      full_set_c[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (valid_in) begin
      wr_idx <= wr_idx + POW'(1);
      if (wr_last_c) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Sample storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem[{wr_bank, wr_idx}] <= wr_data_c;
    end
  end

  // Set and clear target different banks, so ordering between them is irrelevant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else begin
      full <= (full & ~full_clr_c) | full_set_c;
    end
  end

  // Read FSM
  state_t         state;
  state_t         state_d;
  logic [POW-1:0] rd_idx;
  logic [POW-1:0] rd_idx_d;
  logic           rd_bank;
  logic           rd_bank_d;
  logic           rd_other_c;
  logic           rd_en_c;

  assign rd_other_c = ~rd_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_d;
      rd_idx  <= rd_idx_d;
      rd_bank <= rd_bank_d;
    end
  end

  always_comb begin
    state_d    = state;
    rd_idx_d   = rd_idx;
    rd_bank_d  = rd_bank;
    rd_en_c    = 1'b0;
    full_clr_c = '0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_d  = READ;
          rd_idx_d = '0;
        end
      end
      READ: begin
        rd_en_c  = 1'b1;
        rd_idx_d = rd_idx + POW'(1);
        if (rd_idx == LAST_IDX) begin
          full_clr_c[rd_bank] = 1'b1;
          rd_bank_d           = rd_other_c;
          rd_idx_d            = '0;
          // Continue back-to-back if the other bank is already (or just became) full
          if (!(full[rd_other_c] || full_set_c[rd_other_c])) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered RAM read: data and markers of the sample addressed this cycle
  sample_t        rd_data_c;
  logic           s1_valid;
  logic           s1_sop;
  logic           s1_eop;
  logic [POW-1:0] s1_bin;
  sample_t        s1_data;

  assign rd_data_c = mem[{rd_bank, bitrev(rd_idx)}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_bin   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en_c;
      s1_sop   <= rd_en_c && (rd_idx == '0);
      s1_eop   <= rd_en_c && (rd_idx == LAST_IDX);
      if (rd_en_c) begin
        s1_bin  <= rd_idx;
        s1_data <= rd_data_c;
      end
    end
  end

`ifdef FFT_REORDER_MAG_EN
  // Squares never exceed 2^(SW-2), so SW-bit signed products are exact
  logic signed [SW-1:0] re_x_c;
  logic signed [SW-1:0] im_x_c;
  logic signed [SW-1:0] sq_r_c;
  logic signed [SW-1:0] sq_i_c;
  logic [MW-1:0]        mag_c;

  assign re_x_c = SW'($signed(s1_data.re));
  assign im_x_c = SW'($signed(s1_data.im));
  assign sq_r_c = re_x_c * re_x_c;
  assign sq_i_c = im_x_c * im_x_c;
  assign mag_c  = {1'b0, sq_r_c} + {1'b0, sq_i_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      bin_idx    <= '0;
      source_r   <= '0;
      source_i   <= '0;
      source_mag <= '0;
    end else begin
      valid_out <= s1_valid;
      sop       <= s1_sop;
      eop       <= s1_eop;
      if (s1_valid) begin
        bin_idx    <= s1_bin;
        source_r   <= s1_data.re;
        source_i   <= s1_data.im;
        source_mag <= mag_c;
      end
    end
  end
`else
  assign valid_out = s1_valid;
  assign sop       = s1_sop;
  assign eop       = s1_eop;
  assign bin_idx   = s1_bin;
  assign source_r  = s1_data.re;
  assign source_i  = s1_data.im;
`endif

endmodule
